uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a small input FIFO and runtime-selectable parity and stop-bit count. It sits between a byte producer and the serial pin. It is driven by the same single-cycle `tick` from `baudrate_generator`, at OVERSAMPLE ticks per bit. Queued words are sent back-to-back with no idle gap, and completion of each frame is reported with `tx_dv`.

---
 rtl/uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO.
//
// Words pushed through tx_start/tx_in are queued in a circular FIFO and
// serialised onto tx_out as start bit, DATA_WIDTH data bits (LSB first),
// optional parity bit and one or two stop bits.  Bit timing is OVERSAMPLE
// pulses of the external tick strobe per bit.  Queued words go out
// back-to-back with no idle bit, and each finished frame pulses tx_dv.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         one-clock oversampling strobe
//   parity_mode  00/11 none, 01 even, 10 odd (latched per frame at pop)
//   two_stop     0 one stop bit, 1 two stop bits (latched per frame at pop)
//   tx_start     push strobe, accepted on any clock where tx_ready is high
//   tx_in        word to push
//   tx_ready     FIFO not full
//   tx_out       registered serial line, idle high
//   tx_busy      frame in progress or FIFO non-empty
//   tx_dv        one-clock pulse when a frame's last stop bit completes
//   fifo_count   words queued, not counting the word in the shifter

module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          tx_start,
  input  logic [DATA_WIDTH-1:0]         tx_in,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_dv,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even sends the XOR of the data, odd its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic [1:0] mode);
    logic x;
    x = ^data;
    if (mode == 2'b10) begin
      calc_parity = ~x;
    end else begin
      calc_parity = x;
    end
  endfunction

  // Parity is only enabled for the two explicit modes; 00 and 11 mean none.
  function automatic logic parity_enabled(input logic [1:0] mode);
    parity_enabled = (mode == 2'b01) || (mode == 2'b10);
  endfunction

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   stop_bit_q, stop_bit_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   two_stop_q, two_stop_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_dv_q, tx_dv_d;
  logic                   tx_busy_q, tx_busy_d;

  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_empty_s;
  logic                   bit_end_s;

  assign tx_ready     = (count_q != FIFO_FULL);
  assign fifo_empty_s = (count_q == (PW+1)'(0));
  // A push when full is dropped even if a pop frees a slot this same cycle.
  assign push_s       = tx_start && tx_ready;
  assign bit_end_s    = tick && (tick_cnt_q == TICK_LAST);

  assign tx_out     = tx_out_q;
  assign tx_dv      = tx_dv_q;
  assign tx_busy    = tx_busy_q;
  assign fifo_count = count_q;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM: next state, shifter, per-frame config and line value.
  always_comb begin
    state_d    = state_q;
    pop_s      = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_bit_d = stop_bit_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    tick_cnt_d = tick_cnt_q;
    tx_dv_d    = 1'b0;
    tx_out_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          bit_cnt_d = BW'(0);
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_bit_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d    = S_STOP;
          stop_bit_d = 1'b0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (two_stop_q && !stop_bit_q) begin
            // First of two stop bits: stay in STOP for another bit time.
            stop_bit_d = 1'b1;
          end else begin
            tx_dv_d = 1'b1;
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pop loads the shifter and freezes the line config for this frame.
    if (pop_s) begin
      shift_d    = mem_q[rd_ptr_q];
      par_en_d   = parity_enabled(parity_mode);
      par_bit_d  = calc_parity(mem_q[rd_ptr_q], parity_mode);
      two_stop_d = two_stop;
    end else begin
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
    end

    // Tick counter restarts on every state entry and wraps at each bit end.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      tick_cnt_d = CW'(0);
    end else if (bit_end_s) begin
      tick_cnt_d = CW'(0);
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    // The line register follows the state being entered.
    case (state_d)
      S_IDLE:   tx_out_d = 1'b1;
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = par_bit_d;
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase

    tx_busy_d = (state_q != S_IDLE) || !fifo_empty_s;
  end

  // State, FIFO and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
      count_q    <= (PW+1)'(0);
      shift_q    <= DATA_WIDTH'(0);
      tick_cnt_q <= CW'(0);
      bit_cnt_q  <= BW'(0);
      stop_bit_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_dv_q    <= 1'b0;
      tx_busy_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= DATA_WIDTH'(0);
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_bit_q <= stop_bit_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_out_q   <= tx_out_d;
      tx_dv_q    <= tx_dv_d;
      tx_busy_q  <= tx_busy_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= tx_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (8 data bits,
// OVERSAMPLE 16, FIFO depth 4).  Pushed words go into a scoreboard queue
// together with their line config; a monitor samples tx_out on every tick,
// rebuilds each frame from the expected word and compares bit by bit,
// and also checks tx_dv alignment and width.

module tb_uart_tx_fifo;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_start;
  logic [7:0] tx_in;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_dv;
  logic [2:0] fifo_count;

  uart_tx_fifo #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_start(tx_start), .tx_in(tx_in),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .tx_dv(tx_dv), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       ts;
  } sb_t;

  sb_t  sb[$];
  int   gaps[$];
  int   checks = 0;
  int   failures = 0;
  int   frames_done = 0;
  int   dv_count = 0;
  int   samp_idx = 0;
  int   last_end = -1;
  int   fr_cnt = 0;
  int   fr_len = 0;
  int   fr_err = 0;
  logic in_frame = 1'b0;
  logic dv_prev = 1'b0;
  logic [0:11] exp_bits;
  logic [7:0]  fr_data;
  logic tick_en = 1'b0;
  int   ph = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick: one clock high out of every three when enabled
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tick_en && ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: per-tick line samples decoded against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      dv_prev  = 1'b0;
    end else begin
      if (tick === 1'b1) begin
        if (!in_frame && tx_out === 1'b0) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", 32'(sb.size()), 32'd1);
          end else begin
            sb_t e;
            int n;
            e = sb.pop_front();
            fr_data = e.data;
            exp_bits = '1;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[1+i] = e.data[i];
            n = 9;
            if (e.pm == 2'b01) begin
              exp_bits[n] = ^e.data;
              n++;
            end else if (e.pm == 2'b10) begin
              exp_bits[n] = ~(^e.data);
              n++;
            end
            exp_bits[n] = 1'b1;
            n++;
            if (e.ts) begin
              exp_bits[n] = 1'b1;
              n++;
            end
            fr_len = n;
            fr_cnt = 0;
            fr_err = 0;
            in_frame = 1'b1;
            gaps.push_back(samp_idx - last_end - 1);
          end
        end
        if (in_frame) begin
          if (tx_out !== exp_bits[fr_cnt / OS]) fr_err++;
          fr_cnt++;
          if (fr_cnt == fr_len * OS) begin
            check($sformatf("frame_bits_%02h", fr_data), 32'(fr_err), 32'd0);
            frames_done++;
            last_end = samp_idx;
            in_frame = 1'b0;
          end
        end
        samp_idx++;
      end
      if (tx_dv === 1'b1) begin
        dv_count++;
        check("dv_at_frame_end", 32'(frames_done), 32'(dv_count));
        check("dv_one_clk", 32'(dv_prev), 32'd0);
      end
      dv_prev = tx_dv;
    end
  end

  task automatic push_word(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    @(posedge clk);
    #1;
    tx_in = d;
    parity_mode = pm;
    two_stop = ts;
    tx_start = 1'b1;
    sb.push_back('{data: d, pm: pm, ts: ts});
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while ((frames_done < target || dv_count < target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frames"}, 32'(frames_done), 32'(target));
    check({tag, "_dv"}, 32'(dv_count), 32'(target));
  endtask

  initial begin
    int low_cnt;
    int dv_before;
    int fr_before;
    int n;
    rst_n = 1'b0;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    tx_start = 1'b0;
    tx_in = 8'h00;
    tick_en = 1'b1;

    // Reset, then 1000 idle clocks.
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_out !== 1'b1) low_cnt++;
    end
    check("idle_line_low_samples", 32'(low_cnt), 32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_tx_busy", 32'(tx_busy), 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_no_dv", 32'(dv_count), 32'd0);

    // 8N1 0x55 with push-to-line latency.
    push_word(8'h55, 2'b00, 1'b0);
    @(negedge clk);
    check("lat_count_after_push", 32'(fifo_count), 32'd1);
    check("lat_line_after_push", 32'(tx_out), 32'd1);
    @(negedge clk);
    check("lat_count_after_pop", 32'(fifo_count), 32'd0);
    check("lat_line_after_pop", 32'(tx_out), 32'd0);
    check("busy_during_frame", 32'(tx_busy), 32'd1);
    wait_frames(1, 2000, "8n1");
    repeat (3) @(negedge clk);
    check("busy_after_8n1", 32'(tx_busy), 32'd0);

    // Even parity 0x07 then odd parity 0x3C, back to back.
    gaps.delete();
    push_word(8'h07, 2'b01, 1'b0);
    repeat (3) @(posedge clk);
    push_word(8'h3C, 2'b10, 1'b0);
    wait_frames(3, 3000, "parity");
    check("parity_gap", 32'(gaps.size() > 1 ? gaps[1] : -1), 32'd0);

    // Two stop bits, even parity 0xF0; two_stop toggled mid-frame.
    push_word(8'hF0, 2'b01, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    two_stop = 1'b0;
    wait_frames(4, 2000, "two_stop");
    repeat (3) @(negedge clk);
    check("busy_after_two_stop", 32'(tx_busy), 32'd0);

    // FIFO full with tick held low.
    tick_en = 1'b0;
    repeat (4) @(posedge clk);
    gaps.delete();
    @(posedge clk);
    #1;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    tx_in = 8'h01;
    tx_start = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk);
      #1;
      tx_in = 8'(i);
    end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    for (int i = 1; i <= 5; i++) sb.push_back('{data: 8'(i), pm: 2'b00, ts: 1'b0});
    @(negedge clk);
    check("full_fifo_count", 32'(fifo_count), 32'd4);
    check("full_tx_ready", 32'(tx_ready), 32'd0);
    low_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_out !== 1'b0) low_cnt++;
    end
    check("stall_line_stable", 32'(low_cnt), 32'd0);
    tick_en = 1'b1;
    wait_frames(9, 6000, "burst");
    for (int i = 1; i < 5; i++) begin
      check($sformatf("burst_gap_%0d", i), 32'(gaps.size() > i ? gaps[i] : -1), 32'd0);
    end
    check("burst_fifo_drained", 32'(fifo_count), 32'd0);
    check("burst_tx_ready", 32'(tx_ready), 32'd1);

    // Mid-frame reset during data bit 3 of 0xA5 with two words queued.
    push_word(8'hA5, 2'b00, 1'b0);
    push_word(8'h11, 2'b00, 1'b0);
    push_word(8'h22, 2'b00, 1'b0);
    n = 0;
    while (!(in_frame && fr_cnt >= 4 * OS + 8 && fr_cnt < 5 * OS) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reached_data_bit3", 32'(n < 4000), 32'd1);
    check("queued_before_reset", 32'(fifo_count), 32'd2);
    dv_before = dv_count;
    fr_before = frames_done;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_line_async", 32'(tx_out), 32'd1);
    check("reset_count_async", 32'(fifo_count), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx_out !== 1'b1) low_cnt++;
    end
    check("post_reset_line_idle", 32'(low_cnt), 32'd0);
    check("post_reset_no_dv", 32'(dv_count), 32'(dv_before));
    check("post_reset_no_frames", 32'(frames_done), 32'(fr_before));
    check("post_reset_busy", 32'(tx_busy), 32'd0);
    check("post_reset_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
